// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- front-end control stage of the stopwatch.
//   Debounces the start/stop and clear buttons, runs the IDLE/RUN/PAUSE
//   state machine, divides clk into a 1 s tick and keeps the BCD mm:ss count.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   btn_startstop       raw start/stop button, asynchronous to clk
//   btn_clear           raw clear button, asynchronous to clk
//   start               1 = downstream timer held, 0 = counting
//   set                 1-cycle clear pulse to downstream timer
//   running             1 while in RUN
//   sec_tick            1-cycle pulse per counted second
//   sec_ones..min_tens  BCD time digits
//   overflow            sticky, time saturated at 99:59

// Synchroniser + debouncer + rising-edge detector for one button.
// The accepted level follows the synchronised input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; press is registered.
module stopwatch_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1, sync2, level, level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // any cycle where sync2 agrees with the accepted level restarts the count
         if (sync2 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
         level_q <= level;
         press   <= level & ~level_q;
      end
   end
endmodule

module stopwatch_ctrl #(
   parameter int CLK_DIV         = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_startstop,
   input  logic       btn_clear,
   output logic       start,
   output logic       set,
   output logic       running,
   output logic       sec_tick,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       overflow
);
   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, nxt;
   logic [PW-1:0] presc;
   logic          ss_p, clr_p;
   logic          tick, at_max, clr_evt;
   logic [3:0]    so_n, st_n, mo_n, mt_n;

   stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clk(clk), .reset(reset), .raw(btn_startstop), .press(ss_p));
   stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clk(clk), .reset(reset), .raw(btn_clear), .press(clr_p));

   assign tick   = (state == RUN) && (presc == PW'(CLK_DIV - 1));
   assign at_max = (min_tens == 4'd9) && (min_ones == 4'd9) &&
                   (sec_tens == 4'd5) && (sec_ones == 4'd9);

   // BCD carry chain for one second
   always_comb begin
      so_n = sec_ones;
      st_n = sec_tens;
      mo_n = min_ones;
      mt_n = min_tens;
      if (sec_ones == 4'd9) begin
         so_n = 4'd0;
         if (sec_tens == 4'd5) begin
            st_n = 4'd0;
            if (min_ones == 4'd9) begin
               mo_n = 4'd0;
               mt_n = min_tens + 4'd1;
            end else begin
               mo_n = min_ones + 4'd1;
            end
         end else begin
            st_n = sec_tens + 4'd1;
         end
      end else begin
         so_n = sec_ones + 4'd1;
      end
   end

   // Next state. In RUN start/stop beats clear (clear is ignored there);
   // in IDLE/PAUSE clear beats start/stop.
   always_comb begin
      nxt     = state;
      clr_evt = 1'b0;
      case (state)
         IDLE: begin
            if (clr_p) clr_evt = 1'b1;
            else if (ss_p) nxt = RUN;
         end
         RUN: begin
            if (ss_p || (tick && at_max)) nxt = PAUSE;
         end
         PAUSE: begin
            if (clr_p) begin
               nxt     = IDLE;
               clr_evt = 1'b1;
            end else if (ss_p && !overflow) begin
               nxt = RUN;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= '0;
         start    <= 1'b1;
         set      <= 1'b0;
         running  <= 1'b0;
         sec_tick <= 1'b0;
         overflow <= 1'b0;
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else begin
         state    <= nxt;
         running  <= (nxt == RUN);
         start    <= (nxt != RUN);
         set      <= clr_evt;
         // the saturating tick is swallowed: no pulse, digits hold
         sec_tick <= tick & ~at_max;
         if (clr_evt) begin
            presc    <= '0;
            overflow <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
         end else begin
            // prescaler holds outside RUN so a paused partial second survives
            if (state == RUN)
               presc <= (presc == PW'(CLK_DIV - 1)) ? '0 : presc + PW'(1);
            if (tick) begin
               if (at_max) begin
                  overflow <= 1'b1;
               end else begin
                  sec_ones <= so_n;
                  sec_tens <= st_n;
                  min_ones <= mo_n;
                  min_tens <= mt_n;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
   localparam int CLK_DIV = 4;
   localparam int DB      = 3;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic       clk, reset, btn_startstop, btn_clear;
   logic       start, set, running, sec_tick, overflow;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

   stopwatch_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .btn_startstop(btn_startstop), .btn_clear(btn_clear),
      .start(start), .set(set), .running(running), .sec_tick(sec_tick),
      .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
      .overflow(overflow));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;
   int cyc = 0;

   // reference model: time kept as total seconds, buttons as delay line + run length
   int m_secs, m_presc, m_state, m_ovf, m_start, m_set, m_run, m_tick;
   int sh1[2], sh2[2], lv[2], lvq[2], rl[2], pr[2];

   task automatic model_reset();
      m_secs = 0; m_presc = 0; m_state = M_IDLE; m_ovf = 0;
      m_start = 1; m_set = 0; m_run = 0; m_tick = 0;
      for (int b = 0; b < 2; b++) begin
         sh1[b] = 0; sh2[b] = 0; lv[b] = 0; lvq[b] = 0; rl[b] = 0; pr[b] = 0;
      end
   endtask

   task automatic model_edge();
      int raw[2];
      int ss, clr, tk, full, nst, cev;
      raw[0] = int'(btn_startstop);
      raw[1] = int'(btn_clear);
      ss  = pr[0];
      clr = pr[1];
      for (int b = 0; b < 2; b++) begin
         int np;
         np = (lv[b] == 1 && lvq[b] == 0) ? 1 : 0;
         lvq[b] = lv[b];
         if (sh2[b] != lv[b]) begin
            rl[b]++;
            if (rl[b] == DB) begin lv[b] = sh2[b]; rl[b] = 0; end
         end else rl[b] = 0;
         sh2[b] = sh1[b];
         sh1[b] = raw[b];
         pr[b] = np;
      end
      tk   = (m_state == M_RUN && m_presc == CLK_DIV - 1) ? 1 : 0;
      full = (m_secs == 99 * 60 + 59) ? 1 : 0;
      nst = m_state;
      cev = 0;
      if (m_state == M_RUN) begin
         if (ss == 1 || (tk == 1 && full == 1)) nst = M_PAUSE;
      end else if (clr == 1) begin
         nst = M_IDLE; cev = 1;
      end else if (ss == 1 && (m_state == M_IDLE || m_ovf == 0)) begin
         nst = M_RUN;
      end
      if (cev == 1) begin
         m_secs = 0; m_ovf = 0; m_presc = 0;
      end else begin
         if (m_state == M_RUN) m_presc = (m_presc + 1) % CLK_DIV;
         if (tk == 1) begin
            if (full == 1) m_ovf = 1;
            else m_secs++;
         end
      end
      m_tick  = (tk == 1 && full == 0) ? 1 : 0;
      m_set   = cev;
      m_run   = (nst == M_RUN) ? 1 : 0;
      m_start = 1 - m_run;
      m_state = nst;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      int s;
      s = m_secs % 60;
      chk("start",    {3'b0, start},    4'(m_start));
      chk("set",      {3'b0, set},      4'(m_set));
      chk("running",  {3'b0, running},  4'(m_run));
      chk("sec_tick", {3'b0, sec_tick}, 4'(m_tick));
      chk("overflow", {3'b0, overflow}, 4'(m_ovf));
      chk("sec_ones", sec_ones, 4'(s % 10));
      chk("sec_tens", sec_tens, 4'(s / 10));
      chk("min_ones", min_ones, 4'((m_secs / 60) % 10));
      chk("min_tens", min_tens, 4'(m_secs / 600));
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      cyc++;
      @(negedge clk);
      check_all();
      if (sec_tick) tick_seen++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // hold a button pattern, then release long enough for the press to land
   task automatic press(input logic ss, input logic clr, input int hold);
      btn_startstop = ss;
      btn_clear     = clr;
      steps(hold);
      btn_startstop = 1'b0;
      btn_clear     = 1'b0;
      steps(DB + 9);
   endtask

   initial begin
      int n, last, snap;
      reset = 1'b1;
      btn_startstop = 1'b0;
      btn_clear = 1'b0;
      model_reset();
      steps(3);
      chk("rst_start", {3'b0, start}, 4'd1);
      chk("rst_set", {3'b0, set}, 4'd0);
      reset = 1'b0;
      steps(2);

      // 1: press latency, tick rate, counting
      btn_startstop = 1'b1;
      n = 0;
      while (!running && n < 20) begin step(); n++; end
      chk("t1_latency", 4'(n), 4'd7);
      chk("t1_start_low", {3'b0, start}, 4'd0);
      steps(3);
      btn_startstop = 1'b0;
      tick_seen = 0;
      n = 0;
      last = -1;
      while (tick_seen < 12 && n < 200) begin
         step(); n++;
         if (sec_tick) begin
            if (last >= 0) chk("t1_tick_gap", 4'(cyc - last), 4'd4);
            last = cyc;
         end
      end
      chk("t1_sec_ones", sec_ones, 4'd2);
      chk("t1_sec_tens", sec_tens, 4'd1);
      chk("t1_min_ones", min_ones, 4'd0);

      // 2: glitch rejected, held press accepted once, release ignored
      btn_startstop = 1'b1;
      steps(2);
      btn_startstop = 1'b0;
      steps(10);
      chk("t2_glitch_run", {3'b0, running}, 4'd1);
      press(1'b1, 1'b0, 5);
      chk("t2_paused", {3'b0, running}, 4'd0);
      chk("t2_start", {3'b0, start}, 4'd1);

      // 3: pause keeps partial second
      press(1'b0, 1'b1, 5);
      press(1'b1, 1'b0, 5);
      n = 0;
      while (!(m_state == M_RUN && m_secs == 8 && m_presc == 0) && n < 300) begin step(); n++; end
      chk("t3_reach", {3'b0, (n < 300)}, 4'd1);
      btn_startstop = 1'b1;
      steps(7);
      chk("t3_paused", {3'b0, running}, 4'd0);
      chk("t3_start", {3'b0, start}, 4'd1);
      chk("t3_digits", sec_ones, 4'd9);
      btn_startstop = 1'b0;
      steps(15);
      chk("t3_frozen", sec_ones, 4'd9);
      btn_startstop = 1'b1;
      n = 0;
      while (!running && n < 12) begin step(); n++; end
      btn_startstop = 1'b0;
      step();
      chk("t3_tick_now", {3'b0, sec_tick}, 4'd1);
      chk("t3_sec_ones", sec_ones, 4'd0);
      chk("t3_sec_tens", sec_tens, 4'd1);

      // 4: saturate at 99:59
      n = 0;
      while (m_ovf == 0 && n < 30000) begin step(); n++; end
      chk("t4_overflow", {3'b0, overflow}, 4'd1);
      chk("t4_paused", {3'b0, running}, 4'd0);
      chk("t4_mt", min_tens, 4'd9);
      chk("t4_mo", min_ones, 4'd9);
      chk("t4_st", sec_tens, 4'd5);
      chk("t4_so", sec_ones, 4'd9);
      press(1'b1, 1'b0, 5);
      chk("t4_ss_ignored", {3'b0, running}, 4'd0);
      chk("t4_hold", sec_ones, 4'd9);
      btn_clear = 1'b1;
      n = 0;
      while (!set && n < 15) begin step(); n++; end
      chk("t4_set", {3'b0, set}, 4'd1);
      chk("t4_clr_ovf", {3'b0, overflow}, 4'd0);
      chk("t4_clr_mt", min_tens, 4'd0);
      step();
      chk("t4_set_once", {3'b0, set}, 4'd0);
      btn_clear = 1'b0;
      steps(10);

      // 5: coincident presses
      press(1'b1, 1'b0, 5);
      steps(20);
      press(1'b1, 1'b1, 5);
      chk("t5_run_pause", {3'b0, running}, 4'd0);
      snap = m_secs;
      chk("t5_kept_nonzero", {3'b0, (sec_ones != 4'd0 || sec_tens != 4'd0)}, 4'd1);
      steps(10);
      chk("t5_kept", sec_ones, 4'(snap % 10));
      btn_startstop = 1'b1;
      btn_clear = 1'b1;
      n = 0;
      while (!set && n < 15) begin step(); n++; end
      chk("t5_idle_set", {3'b0, set}, 4'd1);
      chk("t5_idle_clr", sec_ones, 4'd0);
      btn_startstop = 1'b0;
      btn_clear = 1'b0;
      steps(12);
      chk("t5_idle_stay", {3'b0, running}, 4'd0);
      press(1'b1, 1'b0, 5);
      btn_clear = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 5) btn_clear = 1'b0;
         chk("t5_clr_ignored", {3'b0, set}, 4'd0);
      end
      chk("t5_still_run", {3'b0, running}, 4'd1);

      // 6: asynchronous reset mid-run
      n = 0;
      while (m_secs != 3 * 60 + 27 && n < 2000) begin step(); n++; end
      chk("t6_at_0327", min_ones, 4'd3);
      #2 reset = 1'b1;
      #1;
      chk("t6_start", {3'b0, start}, 4'd1);
      chk("t6_set", {3'b0, set}, 4'd0);
      chk("t6_running", {3'b0, running}, 4'd0);
      chk("t6_sec_ones", sec_ones, 4'd0);
      chk("t6_min_ones", min_ones, 4'd0);
      model_reset();
      steps(2);
      reset = 1'b0;
      steps(10);

      // random button activity against the model
      for (int i = 0; i < 150; i++) begin
         btn_startstop = 1'($urandom_range(0, 1));
         btn_clear     = 1'($urandom_range(0, 1));
         steps(int'($urandom_range(1, 8)));
      end
      btn_startstop = 1'b0;
      btn_clear = 1'b0;
      steps(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
